// File: rtl/game_pkg.sv
// Shared types and defaults for the runner game's player logic.
package game_pkg;

   typedef enum logic [1:0] {
      LANE_L = 2'd0,
      LANE_M = 2'd1,
      LANE_R = 2'd2
   } lane_t;

   typedef enum logic {
      IDLE = 1'b0,
      MOVE = 1'b1
   } lane_state_t;

   localparam int LANE_DX_DEF = 100;
   localparam int STEP_DEF    = 20;

   // Neighbouring lane; callers have already excluded moves into a wall.
   function automatic lane_t lane_step(input lane_t cur, input logic right);
      return right ? lane_t'(cur + 2'd1) : lane_t'(cur - 2'd1);
   endfunction

endpackage

// File: rtl/debouncer.sv
// Button synchronizer and debouncer producing a one-cycle pulse on each
// accepted press.
module debouncer #(
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_i,
   output logic press_o
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_q, sync2_q;
   logic          level_q, level_d;
   logic          press_q, press_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          accept;

   assign accept = (sync2_q != level_q) && (cnt_q == CNT_MAX);

   always_comb begin
      level_d = level_q;
      cnt_d   = cnt_q + 1'b1;
      press_d = accept && sync2_q;
      if (sync2_q == level_q) begin
         cnt_d = '0;
      end else if (accept) begin
         level_d = sync2_q;
         cnt_d   = '0;
      end
   end

   // NOTE: reset is sampled on the clock edge, so it sits inside the clocked branch.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         press_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= btn_i;
         sync2_q <= sync1_q;
         level_q <= level_d;
         press_q <= press_d;
         cnt_q   <= cnt_d;
      end
   end

   assign press_o = press_q;

endmodule

// File: rtl/lane_controller.sv
// Debounced three-lane player position with per-frame animated horizontal
// offset toward the committed lane.
module lane_controller
   import game_pkg::*;
#(
   parameter int HWIDTH          = 12,
   parameter int LANE_DX         = LANE_DX_DEF,
   parameter int STEP            = STEP_DEF,
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic                     CLK100MHZ,
   input  logic                     CPU_RESETN,
   input  logic                     BTNL,
   input  logic                     BTNR,
   input  logic                     VGA_VS,
   input  logic                     en,
   output logic signed [HWIDTH-1:0] hoffset,
   output logic [1:0]               lane,
   output logic                     moving
);

   typedef logic signed [HWIDTH-1:0] off_t;
   localparam off_t              DX     = off_t'(LANE_DX);
   localparam off_t              STEP_O = off_t'(STEP);
   localparam logic [HWIDTH:0]   STEP_U = (HWIDTH+1)'(STEP);

   logic        press_l, press_r;
   logic        vs1_q, vs2_q, vs3_q, tick_q;
   lane_state_t state_q, state_d;
   lane_t       lane_q, lane_d;
   off_t        hoff_q, hoff_d;
   logic        pend_q, pend_d, pend_dir_q, pend_dir_d;

   debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_l (
      .clk(CLK100MHZ), .rst_n(CPU_RESETN), .btn_i(BTNL), .press_o(press_l)
   );
   debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_r (
      .clk(CLK100MHZ), .rst_n(CPU_RESETN), .btn_i(BTNR), .press_o(press_r)
   );

   logic                   press_valid, press_right, new_ok, take, take_dir;
   off_t                   target;
   logic signed [HWIDTH:0] diff;
   logic [HWIDTH:0]        diff_abs;

   always_comb begin
      state_d     = state_q;
      lane_d      = lane_q;
      hoff_d      = hoff_q;
      pend_d      = pend_q;
      pend_dir_d  = pend_dir_q;
      press_valid = en && (press_l ^ press_r);
      press_right = press_r;
      new_ok      = press_valid &&
                    !(press_right ? (lane_q == LANE_R) : (lane_q == LANE_L));
      take        = new_ok || (pend_q && en);
      take_dir    = new_ok ? press_right : pend_dir_q;
      case (lane_q)
         LANE_L:  target = -DX;
         LANE_R:  target = DX;
         default: target = '0;
      endcase
      diff     = (HWIDTH+1)'(target) - (HWIDTH+1)'(hoff_q);
      diff_abs = diff[HWIDTH] ? $unsigned(-diff) : $unsigned(diff);

      case (state_q)
         IDLE: begin
            if (new_ok) begin
               lane_d  = lane_step(lane_q, press_right);
               state_d = MOVE;
            end
         end
         MOVE: begin
            if (!en) begin
               pend_d = 1'b0;
            end else if (new_ok) begin
               pend_d     = 1'b1;
               pend_dir_d = press_right;
            end
            if (tick_q) begin
               if (diff_abs <= STEP_U) begin
                  // Arrival: a waiting press retargets in the same cycle.
                  hoff_d = target;
                  pend_d = 1'b0;
                  if (take) lane_d = lane_step(lane_q, take_dir);
                  else      state_d = IDLE;
               end else begin
                  hoff_d = diff[HWIDTH] ? hoff_q - STEP_O : hoff_q + STEP_O;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK100MHZ) begin
      if (!CPU_RESETN) begin
         vs1_q      <= 1'b0;
         vs2_q      <= 1'b0;
         vs3_q      <= 1'b0;
         tick_q     <= 1'b0;
         state_q    <= IDLE;
         lane_q     <= LANE_M;
         hoff_q     <= '0;
         pend_q     <= 1'b0;
         pend_dir_q <= 1'b0;
      end else begin
         vs1_q      <= VGA_VS;
         vs2_q      <= vs1_q;
         vs3_q      <= vs2_q;
         tick_q     <= vs2_q && !vs3_q;
         state_q    <= state_d;
         lane_q     <= lane_d;
         hoff_q     <= hoff_d;
         pend_q     <= pend_d;
         pend_dir_q <= pend_dir_d;
      end
   end

   assign hoffset = hoff_q;
   assign lane    = lane_q;
   assign moving  = (state_q == MOVE);

endmodule
